char_anim_sequencer: RTL and testbench
======================================

CHAR_ANIM_SEQUENCER -- requirements
Module: char_anim_sequencer

Interface
REQ-001 The block SHALL have parameter WALK_TICKS, default 6, meaning frame_ticks per walk-cycle half-step.
REQ-002 The block SHALL have parameter LAND_TICKS, default 4, meaning frame_ticks the landing pose is held.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port frame_tick, input, 1 bit: one-cycle pulse per VGA frame (at vblank start).
REQ-007 The block SHALL have port walk_req, input, 1 bit: horizontal move key held.
REQ-008 The block SHALL have port dir, input, 1 bit: move direction, 0 = right, 1 = left.
REQ-009 The block SHALL have port charge, input, 1 bit: jump key held (jump charging).
REQ-010 The block SHALL have port airborne, input, 1 bit: physics reports character not on ground.
REQ-011 The block SHALL have port rising, input, 1 bit: vertical velocity upward; meaningful only when airborne=1.
REQ-012 The block SHALL have port char_id, output, 3 bits: sprite index to the character display controller.
REQ-013 The block SHALL have port char_face, output, 2 bits: 2'b01 = facing right, 2'b10 = facing left.
REQ-014 The block SHALL have port anim_state, output, 3 bits: current FSM state, for debug display.

Function
REQ-015 char_id encoding SHALL be: 0 = stand, 1 = walk A, 2 = walk B, 3 = crouch (charge and land), 4 = rise, 5 = fall; values 6 and 7 SHALL never be output.
REQ-016 The FSM states SHALL be STAND, WALK, CHARGE, RISE, FALL and LAND.
REQ-017 All state, char_id and char_face updates SHALL occur only on the clock edge where frame_tick=1; outputs SHALL be registered and change exactly one cycle after the sampled frame_tick, and SHALL hold otherwise.
REQ-018 On each tick, next state priority SHALL be:
- airborne&rising -> RISE
- airborne&!rising -> FALL
- then per-state ground rules (REQ-019 to REQ-023).
REQ-019 In STAND: charge -> CHARGE; else walk_req -> WALK; else stay.
REQ-020 In WALK:
- charge -> CHARGE; else !walk_req -> STAND;
- else increment the tick counter; on reaching WALK_TICKS-1, toggle char_id 1<->2 and clear the counter.
REQ-021 In CHARGE: !charge -> STAND (jump launch appears as airborne on a later tick).
REQ-022 In RISE: !airborne -> LAND. In FALL: !airborne -> LAND.
REQ-023 In LAND:
- count ticks; after LAND_TICKS ticks in LAND, apply the STAND rules (charge -> CHARGE, walk_req -> WALK, else STAND);
- airborne re-asserted -> RISE/FALL immediately per REQ-018.
REQ-024 char_id per state: STAND=0; WALK enters at 1; CHARGE=3; RISE=4; FALL=5; LAND=3.
REQ-025 The tick counter SHALL clear on every state change; it SHALL saturate, never wrap.
REQ-026 char_face SHALL update from dir on a tick only when walk_req=1 and the next state is STAND, WALK or CHARGE; it SHALL be frozen in RISE, FALL and LAND.
REQ-027 Inputs SHALL be sampled only in the frame_tick cycle; input changes between ticks SHALL have no effect.
REQ-028 anim_state SHALL equal the state register.

Reset
REQ-029 While sys_rst=1, the block SHALL set state=STAND, char_id=0, char_face=2'b01, tick counter=0.
REQ-030 sys_rst SHALL win over a coincident frame_tick.
REQ-031 A reset asserted mid-animation SHALL take effect at the next clock edge; the first post-reset tick SHALL evaluate from STAND.

Structure
REQ-032 A shared package SHALL hold the state encoding, the char_id sprite constants and the face constants, shared with the character display controller and the debug display.
REQ-033 One sub-module, anim_tick_counter, SHALL provide a saturating tick counter with clear and terminal-count flag; it SHALL be instantiated once and sized for max(WALK_TICKS, LAND_TICKS).

Verification
REQ-034 Reset, walk_req=1, dir=0, 13 ticks -> char_id sequence 1 (6 ticks), 2 (6 ticks), 1; char_face=01 throughout.
REQ-035 In WALK, walk_req toggles 0 -> 1 -> 0 between ticks with no tick -> char_id and anim_state unchanged.
REQ-036 charge=1 for 3 ticks; airborne=1, rising=1 for 2 ticks; rising=0 for 2 ticks; airborne=0 -> char_id 3, 4, 5, then 3 for 4 ticks, then 0; dir changes while airborne do not alter char_face.
REQ-037 In LAND, after 2 ticks assert airborne=1, rising=0 -> FALL (char_id 5) on that tick.
REQ-038 Assert sys_rst in the same cycle as frame_tick while in RISE -> next cycle state=STAND, char_id=0, char_face=01.
REQ-039 walk_req=1, dir=1 in STAND -> char_face=10 and char_id=1 one cycle after the tick.

Source files
------------

// File: rtl/char_anim_sequencer_pkg.sv
// Shared encodings for the character animation sequencer:
// FSM states, sprite indices and facing codes.
`timescale 1ns/1ps
package char_anim_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_WALK   = 3'd1,
    ST_CHARGE = 3'd2,
    ST_RISE   = 3'd3,
    ST_FALL   = 3'd4,
    ST_LAND   = 3'd5
  } state_t;

  localparam logic [2:0] SPR_STAND  = 3'd0;
  localparam logic [2:0] SPR_WALK_A = 3'd1;
  localparam logic [2:0] SPR_WALK_B = 3'd2;
  localparam logic [2:0] SPR_CROUCH = 3'd3;
  localparam logic [2:0] SPR_RISE   = 3'd4;
  localparam logic [2:0] SPR_FALL   = 3'd5;

  localparam logic [1:0] FACE_RIGHT = 2'b01;
  localparam logic [1:0] FACE_LEFT  = 2'b10;

  // Ground behaviour shared by STAND and an expired LAND.
  function automatic state_t ground_next(
    input logic charge,
    input logic walk
  );
    if (charge) return ST_CHARGE;
    if (walk)   return ST_WALK;
    return ST_STAND;
  endfunction

  function automatic logic [1:0] face_of(input logic dir);
    return dir ? FACE_LEFT : FACE_RIGHT;
  endfunction

endpackage

// File: rtl/char_anim_sequencer_tick.sv
// Saturating frame-tick counter with clear and terminal flag.
// Ports: i_clk, i_rst, i_clr, i_inc, i_limit -> o_tc.
`timescale 1ns/1ps
module anim_tick_counter
  import char_anim_sequencer_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt >= i_limit);

endmodule

// File: rtl/char_anim_sequencer.sv
// Frame-tick driven sprite/facing sequencer for one character.
// In: sys_clk, sys_rst, frame_tick, walk_req, dir, charge, airborne,
// rising. Out: char_id, char_face, anim_state.
`timescale 1ns/1ps
module char_anim_sequencer
  import char_anim_sequencer_pkg::*;
#(
  parameter int WALK_TICKS = 6,
  parameter int LAND_TICKS = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       frame_tick,
  input  logic       walk_req,
  input  logic       dir,
  input  logic       charge,
  input  logic       airborne,
  input  logic       rising,
  output logic [2:0] char_id,
  output logic [1:0] char_face,
  output logic [2:0] anim_state
);

  localparam int CNT_MAX =
    (WALK_TICKS > LAND_TICKS) ? WALK_TICKS : LAND_TICKS;
  localparam int CW =
    (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_id;
  logic [2:0] w_id_nxt;
  logic [1:0] r_face;
  logic [1:0] w_face_nxt;
  logic       w_clr;
  logic       w_inc;
  logic       w_tc;
  logic [CW-1:0] w_limit;

  // Terminal value is "count-1": the tick that finds the
  // counter there is the last tick of the phase.
  assign w_limit = (r_state == ST_WALK) ?
                   CW'(WALK_TICKS - 1) :
                   CW'(LAND_TICKS - 1);

  anim_tick_counter #(
    .W (CW)
  ) u_cnt (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_STAND;
      r_id    <= SPR_STAND;
      r_face  <= FACE_RIGHT;
    end else begin
      r_state <= w_next;
      r_id    <= w_id_nxt;
      r_face  <= w_face_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_id_nxt   = r_id;
    w_face_nxt = r_face;
    w_clr      = 1'b0;
    w_inc      = 1'b0;
    if (frame_tick) begin
      if (airborne) begin
        w_next = rising ? ST_RISE : ST_FALL;
      end else begin
        unique case (r_state)
          ST_STAND:
            w_next = ground_next(charge, walk_req);
          ST_WALK: begin
            if (charge)         w_next = ST_CHARGE;
            else if (!walk_req) w_next = ST_STAND;
          end
          ST_CHARGE:
            if (!charge) w_next = ST_STAND;
          ST_RISE, ST_FALL:
            w_next = ST_LAND;
          ST_LAND:
            if (w_tc) w_next = ground_next(charge, walk_req);
          default:
            w_next = ST_STAND;
        endcase
      end

      unique case (w_next)
        ST_STAND:  w_id_nxt = SPR_STAND;
        ST_WALK: begin
          if (r_state != ST_WALK) begin
            w_id_nxt = SPR_WALK_A;
          end else if (w_tc) begin
            w_id_nxt = (r_id == SPR_WALK_A) ?
                       SPR_WALK_B : SPR_WALK_A;
          end
        end
        ST_CHARGE: w_id_nxt = SPR_CROUCH;
        ST_RISE:   w_id_nxt = SPR_RISE;
        ST_FALL:   w_id_nxt = SPR_FALL;
        ST_LAND:   w_id_nxt = SPR_CROUCH;
        default:   w_id_nxt = SPR_STAND;
      endcase

      // Facing is frozen while in the air or landing.
      if (walk_req && (w_next inside
          {ST_STAND, ST_WALK, ST_CHARGE})) begin
        w_face_nxt = face_of(dir);
      end

      if ((w_next != r_state) ||
          ((r_state == ST_WALK) && w_tc)) begin
        w_clr = 1'b1;
      end else begin
        w_inc = 1'b1;
      end
    end
  end

  assign char_id    = r_id;
  assign char_face  = r_face;
  assign anim_state = r_state;

endmodule

// File: tb/tb_char_anim_sequencer.sv
// Self-checking bench for char_anim_sequencer: directed
// literal scenarios plus randomized traffic against a model.
`timescale 1ns/1ps
module tb_char_anim_sequencer;
  import char_anim_sequencer_pkg::*;

  localparam int WT = 6;
  localparam int LT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ft  = 1'b0;
  logic wr  = 1'b0;
  logic dr  = 1'b0;
  logic ch  = 1'b0;
  logic ab  = 1'b0;
  logic rs  = 1'b0;
  logic [2:0] id;
  logic [1:0] face;
  logic [2:0] st;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  char_anim_sequencer #(
    .WALK_TICKS (WT),
    .LAND_TICKS (LT)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .frame_tick (ft),
    .walk_req   (wr),
    .dir        (dr),
    .charge     (ch),
    .airborne   (ab),
    .rising     (rs),
    .char_id    (id),
    .char_face  (face),
    .anim_state (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d want %0d",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: walk sprite from ticks-since-entry,
  // landing exit from ticks-since-entry.
  state_t     m_st;
  int         m_walk_n;
  int         m_land_n;
  logic [2:0] m_id;
  logic [1:0] m_face;
  state_t     m_ns;
  int         m_wn_nxt;
  int         m_ln_nxt;

  function automatic state_t on_ground(input logic c,
                                       input logic w);
    if (c) return ST_CHARGE;
    return w ? ST_WALK : ST_STAND;
  endfunction

  function automatic state_t model_next(
    input state_t s, input int ln, input logic w,
    input logic c, input logic a, input logic r);
    if (a) return r ? ST_RISE : ST_FALL;
    case (s)
      ST_STAND:  return on_ground(c, w);
      ST_WALK:   return c ? ST_CHARGE :
                        (w ? ST_WALK : ST_STAND);
      ST_CHARGE: return c ? ST_CHARGE : ST_STAND;
      ST_RISE:   return ST_LAND;
      ST_FALL:   return ST_LAND;
      ST_LAND:   return (ln + 1 >= LT) ?
                        on_ground(c, w) : ST_LAND;
      default:   return ST_STAND;
    endcase
  endfunction

  function automatic logic [2:0] sprite(input state_t s,
                                        input int wn);
    case (s)
      ST_WALK:   return 3'((1 + (wn / WT) % 2));
      ST_CHARGE: return 3'd3;
      ST_LAND:   return 3'd3;
      ST_RISE:   return 3'd4;
      ST_FALL:   return 3'd5;
      default:   return 3'd0;
    endcase
  endfunction

  always_comb begin
    m_ns = model_next(m_st, m_land_n, wr, ch, ab, rs);
    m_wn_nxt = (m_ns == ST_WALK && m_st == ST_WALK) ?
               m_walk_n + 1 : 0;
    m_ln_nxt = (m_ns == ST_LAND && m_st == ST_LAND) ?
               m_land_n + 1 : 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_st     <= ST_STAND;
      m_walk_n <= 0;
      m_land_n <= 0;
      m_id     <= 3'd0;
      m_face   <= 2'b01;
    end else if (ft) begin
      m_st     <= m_ns;
      m_walk_n <= m_wn_nxt;
      m_land_n <= m_ln_nxt;
      m_id     <= sprite(m_ns, m_wn_nxt);
      if (wr && (m_ns == ST_STAND || m_ns == ST_WALK ||
                 m_ns == ST_CHARGE))
        m_face <= dr ? 2'b10 : 2'b01;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_id", {5'd0, id}, {5'd0, m_id});
      chk("model_face", {6'd0, face}, {6'd0, m_face});
      chk("model_state", {5'd0, st}, {5'd0, 3'(m_st)});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input int n);
    for (int k = 0; k < n; k++) begin
      ft = 1'b0;
      wr = 1'($urandom);
      dr = 1'($urandom);
      ch = 1'($urandom);
      ab = 1'($urandom);
      rs = 1'($urandom);
      cyc();
    end
  endtask

  task automatic tick(input logic w, input logic d,
                      input logic c, input logic a,
                      input logic r);
    wr = w; dr = d; ch = c; ab = a; rs = r;
    ft = 1'b1;
    cyc();
    ft = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ft  = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int hold;
  logic [2:0] exp_id;

  initial begin
    cyc();
    cmp_en = 1'b1;
    do_reset();
    chk("rst_id", {5'd0, id}, 8'd0);
    chk("rst_face", {6'd0, face}, 8'd1);
    chk("rst_state", {5'd0, st}, 8'd0);

    // Walk cycle: 1 x6, 2 x6, 1, with input noise between ticks.
    for (int i = 0; i < 13; i++) begin
      noise($urandom_range(0, 2));
      tick(1, 0, 0, 0, 0);
      exp_id = (i < 6) ? 3'd1 : (i < 12) ? 3'd2 : 3'd1;
      chk("walk_id", {5'd0, id}, {5'd0, exp_id});
      chk("walk_face", {6'd0, face}, 8'd1);
    end

    // walk_req toggling without a tick changes nothing.
    wr = 1'b0; cyc();
    wr = 1'b1; cyc();
    wr = 1'b0; cyc();
    chk("hold_id", {5'd0, id}, 8'd1);
    chk("hold_state", {5'd0, st}, {5'd0, 3'(ST_WALK)});

    do_reset();
    tick(1, 1, 0, 0, 0);
    chk("left_face", {6'd0, face}, 8'd2);
    chk("left_id", {5'd0, id}, 8'd1);

    // Charge, jump, fall, land, stand.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0, 0);
      chk("chg_id", {5'd0, id}, 8'd3);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1, 1, 0, 1, 1);
      chk("rise_id", {5'd0, id}, 8'd4);
      chk("rise_face", {6'd0, face}, 8'd1);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1, i[0], 0, 1, 0);
      chk("fall_id", {5'd0, id}, 8'd5);
      chk("fall_face", {6'd0, face}, 8'd1);
    end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0);
      chk("land_id", {5'd0, id}, (i < 4) ? 8'd3 : 8'd0);
    end
    chk("land_end", {5'd0, st}, {5'd0, 3'(ST_STAND)});

    // Re-airborne from LAND goes straight to FALL.
    do_reset();
    tick(0, 0, 0, 1, 0);
    chk("pre_fall", {5'd0, id}, 8'd5);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("in_land", {5'd0, st}, {5'd0, 3'(ST_LAND)});
    tick(0, 0, 0, 1, 0);
    chk("refall_id", {5'd0, id}, 8'd5);
    chk("refall_st", {5'd0, st}, {5'd0, 3'(ST_FALL)});

    // Reset coincident with a tick while rising.
    do_reset();
    tick(0, 0, 0, 1, 1);
    chk("rise_st", {5'd0, st}, {5'd0, 3'(ST_RISE)});
    rst = 1'b1; ft = 1'b1; wr = 1'b1; dr = 1'b1;
    ab = 1'b1; rs = 1'b1;
    cyc();
    rst = 1'b0; ft = 1'b0;
    chk("rt_state", {5'd0, st}, 8'd0);
    chk("rt_id", {5'd0, id}, 8'd0);
    chk("rt_face", {6'd0, face}, 8'd1);
    tick(1, 1, 0, 0, 0);
    chk("post_rst_id", {5'd0, id}, 8'd1);
    chk("post_rst_face", {6'd0, face}, 8'd2);

    // Randomized traffic: inputs held for random spans,
    // ticks and occasional resets sprinkled per cycle.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        wr = ($urandom_range(0, 3) != 0);
        dr = 1'($urandom);
        ch = ($urandom_range(0, 5) == 0);
        ab = ($urandom_range(0, 3) == 0);
        rs = 1'($urandom);
        hold = $urandom_range(1, 30);
      end
      hold--;
      ft  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    ft  = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
